// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: ALUop codes,
// opcode/funct constants, select encodings, FSM state encoding and the
// decoded-instruction record passed from mc_dec to mc_ctrl.
package mc_ctrl_pkg;

  // ALU operation codes consumed by the datapath ALU
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_LUI  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JUMP = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  // Destination register select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // Register write-data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // FSM state encoding; S_JAL is only reachable when jal support is built in
  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_MA    = 4'd3,
    S_MR    = 4'd4,
    S_MW    = 4'd5,
    S_WB    = 4'd6,
    S_BR    = 4'd7,
    S_JMP   = 4'd8,
    S_JAL   = 4'd9
  } state_t;

  // Instruction class flags; exactly one flag is set for any opcode/funct
  typedef struct packed {
    logic       r_alu;     // R-type ALU op (addu/subu/add/and/or/slt/sll)
    logic       i_alu;     // immediate ALU op (addiu/ori/lui)
    logic       sign_ext;  // immediate is sign-extended in EXE (addiu)
    logic       lw;
    logic       sw;
    logic       beq;
    logic       j;
    logic       jal;
    logic       jr;
    logic       illegal;
    logic [3:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mc_dec.sv
// Combinational opcode/funct decode for mc_ctrl. Produces one instruction
// class flag plus the ALUop used in EXE. jal/jr are only recognised when
// MC_JAL_EN is defined; otherwise they fall into the illegal class.
module mc_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Classify the instruction and pick its ALU operation
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADDU;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin dec.r_alu = 1'b1; dec.alu_op = ALU_ADDU; end
          FN_SUBU: begin dec.r_alu = 1'b1; dec.alu_op = ALU_SUBU; end
          FN_ADD:  begin dec.r_alu = 1'b1; dec.alu_op = ALU_ADD;  end
          FN_AND:  begin dec.r_alu = 1'b1; dec.alu_op = ALU_AND;  end
          FN_OR:   begin dec.r_alu = 1'b1; dec.alu_op = ALU_OR;   end
          FN_SLT:  begin dec.r_alu = 1'b1; dec.alu_op = ALU_SLT;  end
          FN_SLL:  begin dec.r_alu = 1'b1; dec.alu_op = ALU_SLL;  end
`ifdef MC_JAL_EN
          FN_JR:   dec.jr = 1'b1;
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        dec.i_alu    = 1'b1;
        dec.sign_ext = 1'b1;
        dec.alu_op   = ALU_ADDU;
      end
      OP_ORI:   begin dec.i_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_LUI:   begin dec.i_alu = 1'b1; dec.alu_op = ALU_LUI; end
      OP_LW:    begin dec.lw = 1'b1;    dec.alu_op = ALU_ADDU; end
      OP_SW:    begin dec.sw = 1'b1;    dec.alu_op = ALU_ADDU; end
      OP_BEQ:   begin dec.beq = 1'b1;   dec.alu_op = ALU_SUBU; end
      OP_J:     dec.j = 1'b1;
`ifdef MC_JAL_EN
      OP_JAL:   dec.jal = 1'b1;
`endif
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. Sequences each instruction through
// FETCH/DCD/EXE/MA/MR/MW/WB/BR/JMP and drives the datapath enables, mux
// selects and ALUop. Outputs are a Moore decode of state plus instr, except
// PCWr in BR which follows zero combinationally. While rst_n is low every
// output is forced to 0.
// Optional feature: define MC_JAL_EN to add jal (JAL state) and jr (via JMP).
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PCWr,
  output logic [1:0]  NPCOp,
  output logic        IRWr,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic        MemWr,
  output logic [3:0]  ALUop,
  output logic        illegal,
  output state_t      dbg_state
);

  state_t state;
  state_t state_nx;
  dec_t   dec;

  // Raw (ungated) output decode
  logic       pcwr_c;
  logic [1:0] npcop_c;
  logic       irwr_c;
  logic       regwr_c;
  logic [1:0] regdst_c;
  logic [1:0] wdsel_c;
  logic       alusrc_c;
  logic       extop_c;
  logic       memwr_c;
  logic [3:0] aluop_c;
  logic       illegal_c;

  // Register/immediate fields are consumed by the datapath, not here
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  mc_dec u_dec (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .dec   (dec)
  );

  // State register; reset returns to FETCH asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state decode; any unlisted state value recovers to FETCH
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH: state_nx = S_DCD;
      S_DCD: begin
        // Class flags are one-hot, so these do not overlap
        state_nx = S_FETCH;
        if (dec.r_alu || dec.i_alu) state_nx = S_EXE;
        if (dec.lw || dec.sw)       state_nx = S_MA;
        if (dec.beq)                state_nx = S_BR;
        if (dec.j)                  state_nx = S_JMP;
`ifdef MC_JAL_EN
        if (dec.jal)                state_nx = S_JAL;
        if (dec.jr)                 state_nx = S_JMP;
`endif
      end
      S_EXE:   state_nx = S_WB;
      S_MA:    state_nx = dec.lw ? S_MR : S_MW;
      S_MR:    state_nx = S_WB;
      S_MW:    state_nx = S_FETCH;
      S_WB:    state_nx = S_FETCH;
      S_BR:    state_nx = S_FETCH;
      S_JMP:   state_nx = S_FETCH;
`ifdef MC_JAL_EN
      S_JAL:   state_nx = S_FETCH;
`endif
      default: state_nx = S_FETCH;
    endcase
  end

  // Output decode from state and the held instruction
  always_comb begin
    pcwr_c    = 1'b0;
    npcop_c   = NPC_PC4;
    irwr_c    = 1'b0;
    regwr_c   = 1'b0;
    regdst_c  = RD_RT;
    wdsel_c   = WD_ALU;
    alusrc_c  = 1'b0;
    extop_c   = 1'b0;
    memwr_c   = 1'b0;
    aluop_c   = ALU_ADDU;
    illegal_c = 1'b0;
    case (state)
      S_FETCH: begin
        irwr_c = 1'b1;
        pcwr_c = 1'b1;
      end
      S_DCD: illegal_c = dec.illegal;
      S_EXE: begin
        aluop_c  = dec.alu_op;
        alusrc_c = dec.i_alu;
        extop_c  = dec.sign_ext;
      end
      S_MA: begin
        aluop_c  = ALU_ADDU;
        alusrc_c = 1'b1;
        extop_c  = 1'b1;
      end
      S_MW: memwr_c = 1'b1;
      S_WB: begin
        regwr_c  = 1'b1;
        regdst_c = dec.r_alu ? RD_RD : RD_RT;
        wdsel_c  = dec.lw ? WD_MEM : WD_ALU;
      end
      S_BR: begin
        aluop_c = ALU_SUBU;
        npcop_c = NPC_BR;
        pcwr_c  = zero;
      end
      S_JMP: begin
        pcwr_c  = 1'b1;
`ifdef MC_JAL_EN
        npcop_c = dec.jr ? NPC_RS : NPC_JUMP;
`else
        npcop_c = NPC_JUMP;
`endif
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        pcwr_c   = 1'b1;
        npcop_c  = NPC_JUMP;
        regwr_c  = 1'b1;
        regdst_c = RD_RA;
        wdsel_c  = WD_PC4;
      end
`endif
      default: ;
    endcase
  end

  // Reset forces every enable, select and ALUop to zero immediately
  assign PCWr      = rst_n & pcwr_c;
  assign NPCOp     = rst_n ? npcop_c  : 2'b00;
  assign IRWr      = rst_n & irwr_c;
  assign RegWr     = rst_n & regwr_c;
  assign RegDst    = rst_n ? regdst_c : 2'b00;
  assign WDSel     = rst_n ? wdsel_c  : 2'b00;
  assign ALUSrc    = rst_n & alusrc_c;
  assign ExtOp     = rst_n & extop_c;
  assign MemWr     = rst_n & memwr_c;
  assign ALUop     = rst_n ? aluop_c  : 4'd0;
  assign illegal   = rst_n & illegal_c;
  assign dbg_state = state;

endmodule
